// File: rtl/bk_pkg.sv
// Shared types and constants for the backup-RAM save/load sequencer.
package bk_pkg;

  localparam int SECTOR_BITS = 9;
  localparam int LBA_W       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } bk_state_t;

endpackage

// File: rtl/bk_if.sv
// Control/status bundle between the OSD/hps_io side and the backup-RAM sequencer.
interface bk_if;
  import bk_pkg::*;

  logic             ioctl_download;
  logic             img_mounted;
  logic             img_readonly;
  logic [63:0]      img_size;
  logic             bk_load;
  logic             bk_save;
  logic [23:0]      ram_mask;
  logic             sd_ack;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             bk_loading;
  logic             bk_busy;
  logic             bk_ena;

  modport master (
    input  ioctl_download, img_mounted, img_readonly, img_size,
    input  bk_load, bk_save, ram_mask, sd_ack,
    output sd_lba, sd_rd, sd_wr, bk_loading, bk_busy, bk_ena
  );

  modport slave (
    output ioctl_download, img_mounted, img_readonly, img_size,
    output bk_load, bk_save, ram_mask, sd_ack,
    input  sd_lba, sd_rd, sd_wr, bk_loading, bk_busy, bk_ena
  );

endinterface

// File: rtl/bk_edge_det.sv
// Rise/fall detector: registers the input once and compares against the live value.
module bk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/bk_sequencer.sv
// Backup-RAM sector sequencer: walks sd_lba from 0 to the last sector, issuing sd_rd/sd_wr.
// Optional BK_AUTOLOAD_EN: start a load automatically when a ROM download ends.
module bk_sequencer
  import bk_pkg::*;
#(
  parameter int BSRAM_BITS = 15
) (
  input  logic clk_sys,
  input  logic reset,
  bk_if.master bus
);

  localparam int               CAP_W      = BSRAM_BITS - SECTOR_BITS;
  localparam logic [LBA_W-1:0] SECTOR_CAP = LBA_W'((1 << CAP_W) - 1);

  bk_state_t        r_state;
  logic [LBA_W-1:0] r_lba;
  logic             r_rd;
  logic             r_wr;
  logic             r_loading;
  logic             r_ena;

  logic             w_load_rise, w_load_fall;
  logic             w_save_rise, w_save_fall;
  logic             w_dl_rise,   w_dl_fall;
  logic             w_ack_rise,  w_ack_fall;
  logic             w_start_load;
  logic             w_start;
  logic             w_ena_set;
  logic [LBA_W-1:0] w_mask_last;
  logic [LBA_W-1:0] w_last;
  logic             w_unused_bits;

  bk_edge_det u_load_ed (
    .clk(clk_sys), .rst(reset), .i_d(bus.bk_load & r_ena),
    .o_rise(w_load_rise), .o_fall(w_load_fall)
  );

  bk_edge_det u_save_ed (
    .clk(clk_sys), .rst(reset), .i_d(bus.bk_save & r_ena),
    .o_rise(w_save_rise), .o_fall(w_save_fall)
  );

  bk_edge_det u_dl_ed (
    .clk(clk_sys), .rst(reset), .i_d(bus.ioctl_download),
    .o_rise(w_dl_rise), .o_fall(w_dl_fall)
  );

  bk_edge_det u_ack_ed (
    .clk(clk_sys), .rst(reset), .i_d(bus.sd_ack),
    .o_rise(w_ack_rise), .o_fall(w_ack_fall)
  );

  // The cartridge mask can describe more sectors than the backup RAM holds; clamp it.
  assign w_mask_last = LBA_W'(bus.ram_mask[23:SECTOR_BITS]);
  assign w_last      = (w_mask_last < SECTOR_CAP) ? w_mask_last : SECTOR_CAP;

`ifdef BK_AUTOLOAD_EN
  assign w_start_load = w_load_rise | (w_dl_fall & r_ena);
`else
  assign w_start_load = w_load_rise;
`endif

  assign w_start   = w_start_load | w_save_rise;
  assign w_ena_set = bus.ioctl_download & bus.img_mounted &
                     (bus.img_size != 64'd0) & ~bus.img_readonly;

  assign w_unused_bits = ^{w_load_fall, w_save_fall, w_dl_fall,
                           bus.ram_mask[SECTOR_BITS-1:0]};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lba     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_loading <= 1'b0;
      r_ena     <= 1'b0;
    end else begin
      if (w_dl_rise) r_ena <= 1'b0;
      if (w_ena_set) r_ena <= 1'b1;

      // A new download invalidates whatever transfer is under way.
      if (w_dl_rise && (r_state != IDLE)) begin
        r_state   <= IDLE;
        r_rd      <= 1'b0;
        r_wr      <= 1'b0;
        r_loading <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_state   <= REQ;
              r_lba     <= '0;
              r_loading <= w_start_load;
              r_rd      <= w_start_load;
              r_wr      <= ~w_start_load;
            end
          end
          REQ: begin
            if (w_ack_rise) begin
              r_rd    <= 1'b0;
              r_wr    <= 1'b0;
              r_state <= XFER;
            end
          end
          XFER: begin
            if (w_ack_fall) begin
              if (r_lba >= w_last) begin
                r_state   <= IDLE;
                r_loading <= 1'b0;
              end else begin
                // r_loading doubles as the transfer direction for the next sector.
                r_lba   <= r_lba + LBA_W'(1);
                r_rd    <= r_loading;
                r_wr    <= ~r_loading;
                r_state <= REQ;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sd_lba     = r_lba;
  assign bus.sd_rd      = r_rd;
  assign bus.sd_wr      = r_wr;
  assign bus.bk_loading = r_loading;
  assign bus.bk_ena     = r_ena;
  assign bus.bk_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_bk_sequencer.sv
// Directed bench for bk_sequencer: enable table plus save/load/abort/reset sequences.
module tb_bk_sequencer;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  bk_if bus ();

  bk_sequencer #(.BSRAM_BITS(15)) u_dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dl;
    logic        mnt;
    logic [63:0] size;
    logic        ro;
    logic        exp_ena;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ioctl_download = 1'b0;
    bus.img_mounted    = 1'b0;
    bus.img_readonly   = 1'b0;
    bus.img_size       = 64'd0;
    bus.bk_load        = 1'b0;
    bus.bk_save        = 1'b0;
    bus.ram_mask       = 24'd0;
    bus.sd_ack         = 1'b0;
  endtask

  // Reset, then mount a writable image during a download; leaves ioctl_download high.
  task automatic setup(input logic [23:0] mask);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ram_mask       = mask;
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    bus.img_mounted = 1'b1;
    bus.img_size    = 64'd32768;
    @(negedge clk);
    bus.img_mounted = 1'b0;
    @(negedge clk);
    chk("setup_ena", bus.bk_ena, 1);
  endtask

  // Answer one sector request like hps_io: ack after dly cycles, hold 3 cycles, release.
  task automatic serve(input int dly, output logic seen, output logic [31:0] lba,
                       output logic rd, output logic wr, output logic ld);
    seen = 1'b0;
    lba  = '0;
    rd   = 1'b0;
    wr   = 1'b0;
    ld   = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (bus.sd_rd | bus.sd_wr) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) return;
    lba = bus.sd_lba;
    rd  = bus.sd_rd;
    wr  = bus.sd_wr;
    ld  = bus.bk_loading;
    repeat (dly) @(negedge clk);
    bus.sd_ack = 1'b1;
    @(negedge clk);
    chk("req_drop_on_ack", {bus.sd_rd, bus.sd_wr, bus.bk_busy}, 3'b001);
    repeat (2) @(negedge clk);
    bus.sd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int hits;
    hits = 0;
    for (int t = 0; t < cycles; t++) begin
      if (bus.sd_rd | bus.sd_wr) hits++;
      @(negedge clk);
    end
    chk(name, hits, 0);
  endtask

  initial begin
    logic        seen, rd, wr, ld;
    logic [31:0] lba;
    int          errs;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{dl: 1'b0, mnt: 1'b1, size: 64'd4096,          ro: 1'b0, exp_ena: 1'b0};
    vecs[1] = '{dl: 1'b1, mnt: 1'b1, size: 64'd4096,          ro: 1'b0, exp_ena: 1'b1};
    vecs[2] = '{dl: 1'b1, mnt: 1'b1, size: 64'd0,             ro: 1'b0, exp_ena: 1'b0};
    vecs[3] = '{dl: 1'b1, mnt: 1'b1, size: 64'd4096,          ro: 1'b1, exp_ena: 1'b0};
    vecs[4] = '{dl: 1'b1, mnt: 1'b0, size: 64'd4096,          ro: 1'b0, exp_ena: 1'b0};
    vecs[5] = '{dl: 1'b1, mnt: 1'b1, size: 64'h1_0000_0000,   ro: 1'b0, exp_ena: 1'b1};

    // Reset state, observed while reset is held.
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_lba",     bus.sd_lba, 0);
    chk("rst_rd_wr",   {bus.sd_rd, bus.sd_wr}, 0);
    chk("rst_loading", bus.bk_loading, 0);
    chk("rst_ena",     bus.bk_ena, 0);
    chk("rst_busy",    bus.bk_busy, 0);

    // Enable table: mount conditions, then a bk_load must start a read only if enabled.
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      bus.ram_mask = 24'h0007FF;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.ioctl_download = vecs[i].dl;
      @(negedge clk);
      bus.img_mounted  = vecs[i].mnt;
      bus.img_size     = vecs[i].size;
      bus.img_readonly = vecs[i].ro;
      @(negedge clk);
      bus.img_mounted = 1'b0;
      chk($sformatf("vec%0d_ena", i), bus.bk_ena, vecs[i].exp_ena);
      bus.bk_load = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_rd", i),   bus.sd_rd, vecs[i].exp_ena);
      chk($sformatf("vec%0d_wr", i),   bus.sd_wr, 0);
      chk($sformatf("vec%0d_busy", i), bus.bk_busy, vecs[i].exp_ena);
      bus.bk_load = 1'b0;
      @(negedge clk);
    end

    // Save of four sectors (mask last sector = 3).
    setup(24'h0007FF);
    bus.bk_save = 1'b1;
    @(negedge clk);
    bus.bk_save = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve(5, seen, lba, rd, wr, ld);
      chk($sformatf("save%0d_seen", i), seen, 1);
      chk($sformatf("save%0d_lba", i),  lba, i);
      chk($sformatf("save%0d_dir", i),  {rd, wr, ld}, 3'b010);
    end
    chk("save_end_busy", bus.bk_busy, 0);
    expect_quiet("save_no_extra", 10);

    // Load clamps to 64 sectors although the mask asks for 256.
    setup(24'h01FFFF);
    bus.bk_load = 1'b1;
    @(negedge clk);
    bus.bk_load = 1'b0;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      serve(1, seen, lba, rd, wr, ld);
      if (!seen || lba != i || !rd || wr || !ld) errs++;
    end
    chk("load_seq_errs",    errs, 0);
    chk("load_final_lba",   bus.sd_lba, 63);
    chk("load_end_loading", bus.bk_loading, 0);
    chk("load_end_busy",    bus.bk_busy, 0);
    expect_quiet("load_no_extra", 20);

    // Simultaneous load/save: load wins, and a save pulse mid-transfer is dropped.
    setup(24'h0007FF);
    bus.bk_load = 1'b1;
    bus.bk_save = 1'b1;
    @(negedge clk);
    chk("both_dir", {bus.sd_rd, bus.sd_wr, bus.bk_loading}, 3'b101);
    bus.bk_load = 1'b0;
    bus.bk_save = 1'b0;
    serve(2, seen, lba, rd, wr, ld);
    chk("both_s0", {seen, rd, wr}, 3'b110);
    bus.bk_save = 1'b1;
    @(negedge clk);
    bus.bk_save = 1'b0;
    errs = 0;
    for (int i = 1; i < 4; i++) begin
      serve(2, seen, lba, rd, wr, ld);
      if (!seen || lba != i || !rd || wr) errs++;
    end
    chk("both_rest_errs", errs, 0);
    chk("both_end_busy", bus.bk_busy, 0);
    expect_quiet("both_no_save", 10);

    // Abort by a new download while transferring sector 2.
    setup(24'h0007FF);
    bus.ioctl_download = 1'b0;
    bus.bk_load        = 1'b1;
    @(negedge clk);
    bus.bk_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      serve(2, seen, lba, rd, wr, ld);
      chk($sformatf("abort_s%0d", i), {seen, lba[3:0], rd}, {1'b1, 4'(i), 1'b1});
    end
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (bus.sd_rd) seen = 1'b1;
      else @(negedge clk);
    end
    chk("abort_req2_seen", seen, 1);
    chk("abort_req2_lba",  bus.sd_lba, 2);
    repeat (3) @(negedge clk);
    bus.sd_ack = 1'b1;
    @(negedge clk);
    chk("abort_in_xfer", {bus.bk_busy, bus.sd_rd}, 2'b10);
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    chk("abort_busy",    bus.bk_busy, 0);
    chk("abort_rd_wr",   {bus.sd_rd, bus.sd_wr}, 0);
    chk("abort_loading", bus.bk_loading, 0);
    chk("abort_ena",     bus.bk_ena, 0);
    bus.sd_ack = 1'b0;
    @(negedge clk);
    expect_quiet("abort_no_resume", 10);

    // Reset mid-transfer abandons the load for good.
    setup(24'h0007FF);
    bus.bk_load = 1'b1;
    @(negedge clk);
    bus.bk_load = 1'b0;
    serve(2, seen, lba, rd, wr, ld);
    chk("rstmid_s0", {seen, rd}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rstmid_busy",  bus.bk_busy, 0);
    chk("rstmid_state", {bus.sd_rd, bus.sd_wr, bus.bk_loading, bus.bk_ena}, 0);
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("rstmid_no_resume", 10);

    // Falling edge of a download with a writable image mounted.
    setup(24'h0007FF);
    bus.ioctl_download = 1'b0;
    @(negedge clk);
`ifdef BK_AUTOLOAD_EN
    chk("auto_rd",  {bus.sd_rd, bus.sd_wr, bus.bk_loading}, 3'b101);
    chk("auto_lba", bus.sd_lba, 0);
`else
    chk("auto_rd",  {bus.sd_rd, bus.sd_wr, bus.bk_loading}, 3'b000);
    chk("auto_busy", bus.bk_busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bk_sequencer.md
BK_SEQUENCER -- requirements
Module: bk_sequencer

Interface
REQ-001 BSRAM_BITS, 15, log2 of backup-RAM bytes; the sector cap is 2^(BSRAM_BITS-9)-1.
REQ-002 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ioctl_download  in  1  ROM download in progress.
REQ-005 img_mounted  in  1  one-cycle pulse when a save image is mounted.
REQ-006 img_readonly  in  1  mounted image is read-only.
REQ-007 img_size  in  64  mounted image size in bytes.
REQ-008 bk_load  in  1  manual load request, level from the OSD.
REQ-009 bk_save  in  1  manual save request, level from the OSD.
REQ-010 ram_mask  in  24  cartridge SRAM byte mask; bits [23:9] give the last sector index.
REQ-011 sd_ack  in  1  sector transfer acknowledge from hps_io.
REQ-012 sd_lba  out  32  current sector index.
REQ-013 sd_rd  out  1  sector read request.
REQ-014 sd_wr  out  1  sector write request.
REQ-015 bk_loading  out  1  load in progress; the core is held in reset while it is high.
REQ-016 bk_busy  out  1  the state machine is not in IDLE.
REQ-017 bk_ena  out  1  a writable save image is available.

Function
REQ-018 States: IDLE, REQ and XFER, encoded per the shared package enum.
REQ-019 bk_ena SHALL clear on a rising edge of ioctl_download, and SHALL set on any cycle with ioctl_download & img_mounted & (img_size!=0) & ~img_readonly.
REQ-020 Load trigger: rising edge of (bk_load & bk_ena), detected from a registered copy of that signal.
REQ-021 Save trigger: rising edge of (bk_save & bk_ena), detected the same way.
REQ-022 If load and save triggers occur in the same cycle, load SHALL win.
REQ-023 A trigger in IDLE SHALL, on the next edge:
- enter REQ;
- set sd_lba=0;
- set bk_loading=load;
- set sd_rd=load and sd_wr=~load.
REQ-024 Triggers arriving while not in IDLE SHALL be dropped, not queued.
REQ-025 REQ: on the first cycle sd_ack is sampled high after being low, sd_rd and sd_wr SHALL deassert on the next edge and the state SHALL become XFER.
REQ-026 XFER: on sd_ack falling edge, the sequencer SHALL check the current sector:
- if sd_lba >= last, go to IDLE and clear bk_loading;
- otherwise increment sd_lba, re-assert the same request (rd or wr) and return to REQ.
REQ-027 last = min(ram_mask[23:9], 2^(BSRAM_BITS-9)-1); the comparison is unsigned at 32 bits, zero-extended.
REQ-028 sd_rd and sd_wr SHALL never be high together.
REQ-029 A rising edge of ioctl_download in any non-IDLE state SHALL abort: go to IDLE and clear sd_rd, sd_wr and bk_loading on the next edge.
REQ-030 bk_busy SHALL equal (state != IDLE), driven combinationally.

Reset
REQ-031 While reset is high, all of the following SHALL hold asynchronously:
- state=IDLE;
- sd_lba=0;
- sd_rd=0, sd_wr=0;
- bk_loading=0;
- bk_ena=0;
- all edge-detect registers cleared.
REQ-032 A reset asserted mid-transfer SHALL abandon the transfer; no resumption after release.

Configuration
REQ-033 Macro BK_AUTOLOAD_EN, when defined: a falling edge of ioctl_download while bk_ena=1 and state=IDLE SHALL start a load exactly as in REQ-023.
REQ-034 When BK_AUTOLOAD_EN is undefined, only the manual triggers of REQ-020/021 start transfers; the auto-load logic is absent.

Structure
REQ-035 A shared package bk_pkg SHALL hold:
- the state enum (IDLE, REQ, XFER);
- SECTOR_BITS=9;
- LBA_W=32.
REQ-036 One sub-module, bk_edge_det (registered rise and fall detector), SHALL be instantiated for load, save, ioctl_download and sd_ack.

Verification
REQ-037 Save with ram_mask=0x0007FF and bk_ena=1, bk_save pulse, acks answered after 5 cycles -> four sd_wr requests with sd_lba 0,1,2,3, then IDLE, with bk_loading=0 throughout.
REQ-038 Load with ram_mask=0x01FFFF and BSRAM_BITS=15 -> sd_lba stops at 63, not 255; bk_loading is high from the first request until the last ack falls.
REQ-039 bk_load and bk_save rising in the same cycle -> sd_rd=1 and sd_wr=0; a bk_save pulse during the transfer is ignored.
REQ-040 Abort: ioctl_download rises while at sd_lba=2 in XFER -> next cycle state=IDLE, sd_rd=sd_wr=bk_loading=0, bk_ena=0.
REQ-041 Permissions: img_readonly=1 on mount -> bk_ena stays 0 and bk_load produces no sd_rd.
REQ-042 Auto-load: with BK_AUTOLOAD_EN defined, download ends with bk_ena=1 -> sd_rd at lba 0 one cycle after the falling edge; with the macro undefined, no request is issued.
